// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: register-file write-back arbiter, registered write stage and RAW/WAW busy scoreboard.
// Define WBCTRL_FIXED_PRIO_EN for fixed load-over-ALU priority instead of round-robin.
module regfile_wb_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  output logic            stall,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [AW-1:0]   m_rd,
  input  logic [XLEN-1:0] m_data,
  output logic            RegWEn,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] Writedata,
  output logic [NREG-1:0] busy
);
  logic            acc;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] set_vec, clr_vec;
`ifdef WBCTRL_FIXED_PRIO_EN
  assign m_ready = rst & m_valid;
  assign a_ready = rst & a_valid & ~m_valid;
`else
  logic last_m;
  // ready is gated by rst so nothing is granted while reset is held
  assign a_ready = rst & a_valid & (~m_valid | last_m);
  assign m_ready = rst & m_valid & ~a_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_m <= 1'b1;
    else if (acc) last_m <= m_ready;
`endif
  assign acc      = a_ready | m_ready;
  assign sel_rd   = a_ready ? a_rd : m_rd;
  assign sel_data = a_ready ? a_data : m_data;
  assign stall    = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]);
  assign set_vec  = (iss_valid & ~stall & (iss_rd != '0)) ? (NREG'(1) << iss_rd) : '0;
  assign clr_vec  = RegWEn ? (NREG'(1) << rd) : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      RegWEn    <= 1'b0;
      rd        <= '0;
      Writedata <= '0;
      busy      <= '0;
    end else begin
      RegWEn <= acc & (sel_rd != '0);
      if (acc) begin
        rd        <= sel_rd;
        Writedata <= sel_data;
      end
      busy <= (busy & ~clr_vec) | set_vec;
    end
endmodule
